reg_load_unit: RTL and testbench

Memory-to-register load engine. Accepts a load command (address, destination register, size mode), fetches one or two bytes over an 8-bit request/acknowledge memory port, assembles the result, and drives the register file's write port: `we`, 3-bit destination, 16-bit data, and `hb`/`lb` byte enables. It is the producer for that write port and sits between the core's decode/execute stage and the register file.

---
 rtl/reg_load_unit.sv | 168 ++++++++++++++++
 tb/tb_reg_load_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_unit.sv
// Memory-to-register load engine: fetches one or two bytes over a req/ack
// byte port and writes the assembled value to the register file.
module reg_load_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] addr,
   input  logic [2:0]  dest,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic        rf_we,
   output logic [2:0]  rf_dest,
   output logic [15:0] rf_data,
   output logic        rf_hb,
   output logic        rf_lb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      WB   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_WORD  = 2'b00,
      MODE_LOW   = 2'b01,
      MODE_HIGH  = 2'b10,
      MODE_SEXT  = 2'b11
   } mode_e;

   typedef struct packed {
      logic        hb;
      logic        lb;
      logic [15:0] data;
   } wr_t;

   state_e      state_q;
   mode_e       mode_q;
   logic [15:0] addr_q;
   logic [2:0]  dest_q;
   logic [7:0]  byte0_q;

   logic        busy_q;
   logic        done_q;
   logic        mem_req_q;
   logic [15:0] mem_addr_q;
   logic        rf_we_q;
   logic [2:0]  rf_dest_q;
   logic [15:0] rf_data_q;
   logic        rf_hb_q;
   logic        rf_lb_q;

   logic [15:0] addr_inc_d;
   wr_t         wr_byte_d;
   wr_t         wr_word_d;

   function automatic wr_t assemble(input mode_e m, input logic [7:0] b1, input logic [7:0] b0);
      wr_t w;
      unique case (m)
         MODE_WORD: w = '{hb: 1'b1, lb: 1'b1, data: {b1, b0}};
         MODE_LOW:  w = '{hb: 1'b0, lb: 1'b1, data: {8'h00, b0}};
         MODE_HIGH: w = '{hb: 1'b1, lb: 1'b0, data: {b0, 8'h00}};
         default:   w = '{hb: 1'b1, lb: 1'b1, data: {{8{b0[7]}}, b0}};
      endcase
      return w;
   endfunction

   // Second byte address wraps modulo 2^16 through natural 16-bit overflow.
   always_comb begin
      addr_inc_d = addr_q + 16'd1;
      wr_byte_d  = assemble(mode_q, 8'h00, mem_data);
      wr_word_d  = assemble(mode_q, mem_data, byte0_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_WORD;
         addr_q     <= '0;
         dest_q     <= '0;
         byte0_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         rf_we_q    <= 1'b0;
         rf_dest_q  <= '0;
         rf_data_q  <= '0;
         rf_hb_q    <= 1'b0;
         rf_lb_q    <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         rf_we_q   <= 1'b0;
         rf_dest_q <= '0;
         rf_data_q <= '0;
         rf_hb_q   <= 1'b0;
         rf_lb_q   <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q     <= addr;
                  dest_q     <= dest;
                  mode_q     <= mode_e'(mode);
                  busy_q     <= 1'b1;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= addr;
                  state_q    <= RD0;
               end
            end
            RD0: begin
               if (mem_ack) begin
                  byte0_q <= mem_data;
                  if (mode_q == MODE_WORD) begin
                     mem_addr_q <= addr_inc_d;
                     state_q    <= RD1;
                  end else begin
                     mem_req_q  <= 1'b0;
                     mem_addr_q <= '0;
                     done_q     <= 1'b1;
                     rf_we_q    <= 1'b1;
                     rf_dest_q  <= dest_q;
                     rf_data_q  <= wr_byte_d.data;
                     rf_hb_q    <= wr_byte_d.hb;
                     rf_lb_q    <= wr_byte_d.lb;
                     state_q    <= WB;
                  end
               end
            end
            RD1: begin
               if (mem_ack) begin
                  mem_req_q  <= 1'b0;
                  mem_addr_q <= '0;
                  done_q     <= 1'b1;
                  rf_we_q    <= 1'b1;
                  rf_dest_q  <= dest_q;
                  rf_data_q  <= wr_word_d.data;
                  rf_hb_q    <= wr_word_d.hb;
                  rf_lb_q    <= wr_word_d.lb;
                  state_q    <= WB;
               end
            end
            WB: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign rf_we    = rf_we_q;
   assign rf_dest  = rf_dest_q;
   assign rf_data  = rf_data_q;
   assign rf_hb    = rf_hb_q;
   assign rf_lb    = rf_lb_q;

endmodule

// File: tb/tb_reg_load_unit.sv
// Self-checking bench for reg_load_unit: byte-counting transaction model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_reg_load_unit;

   logic        clk = 1'b0;
   logic        rst, start, mem_ack;
   logic [15:0] addr;
   logic [2:0]  dest;
   logic [1:0]  mode;
   logic [7:0]  mem_data;
   logic        busy, done, mem_req, rf_we, rf_hb, rf_lb;
   logic [15:0] mem_addr, rf_data;
   logic [2:0]  rf_dest;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Model: an outstanding command needs N bytes; each ack adds one byte.
   bit          m_active = 0;
   bit          m_wb = 0;
   int          m_need = 0;
   int          m_got = 0;
   logic [15:0] m_addr = '0;
   logic [2:0]  m_dest = '0;
   logic [1:0]  m_mode = '0;
   logic [7:0]  m_byte [2];

   always #5 clk = ~clk;

   reg_load_unit dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .dest(dest), .mode(mode),
      .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .rf_we(rf_we), .rf_dest(rf_dest),
      .rf_data(rf_data), .rf_hb(rf_hb), .rf_lb(rf_lb)
   );

   function automatic logic [15:0] model_data();
      int v;
      case (m_mode)
         2'd0:    v = int'(m_byte[1]) * 256 + int'(m_byte[0]);
         2'd1:    v = int'(m_byte[0]);
         2'd2:    v = int'(m_byte[0]) * 256;
         default: v = (m_byte[0] >= 8'd128) ? 32'hFF00 + int'(m_byte[0]) : int'(m_byte[0]);
      endcase
      return v[15:0];
   endfunction

   task automatic field(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_cycle();
      logic        e_req;
      logic [15:0] e_maddr;
      e_req   = m_active && !m_wb;
      e_maddr = e_req ? 16'(m_addr + 16'(m_got)) : 16'h0000;
      vectors++;
      field("busy",     32'(busy),     32'(m_active));
      field("mem_req",  32'(mem_req),  32'(e_req));
      field("mem_addr", 32'(mem_addr), 32'(e_maddr));
      field("done",     32'(done),     32'(m_wb));
      field("rf_we",    32'(rf_we),    32'(m_wb));
      field("rf_dest",  32'(rf_dest),  m_wb ? 32'(m_dest) : 32'h0);
      field("rf_data",  32'(rf_data),  m_wb ? 32'(model_data()) : 32'h0);
      field("rf_hb",    32'(rf_hb),    32'(m_wb && m_mode != 2'd1));
      field("rf_lb",    32'(rf_lb),    32'(m_wb && m_mode != 2'd2));
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      field(name, act, exp);
   endtask

   task automatic model_step(input bit r, input bit s, input logic [15:0] a, input logic [2:0] d,
                             input logic [1:0] md, input bit ack, input logic [7:0] data);
      if (r) begin
         m_active = 0;
         m_wb     = 0;
      end else if (m_wb) begin
         m_active = 0;
         m_wb     = 0;
      end else if (m_active) begin
         if (ack) begin
            m_byte[m_got] = data;
            m_got++;
            if (m_got == m_need) m_wb = 1;
         end
      end else if (s) begin
         m_active = 1;
         m_got    = 0;
         m_need   = (md == 2'd0) ? 2 : 1;
         m_addr   = a;
         m_dest   = d;
         m_mode   = md;
      end
   endtask

   task automatic step(input bit r, input bit s, input logic [15:0] a, input logic [2:0] d,
                       input logic [1:0] md, input bit ack, input logic [7:0] data);
      rst = r; start = s; addr = a; dest = d; mode = md; mem_ack = ack; mem_data = data;
      model_step(r, s, a, d, md, ack, data);
      @(posedge clk);
      @(negedge clk);
      check_cycle();
   endtask

   task automatic idle(input bit ack);
      step(0, 0, 16'h0, 3'd0, 2'd0, ack, 8'h00);
   endtask

   initial begin
      logic [15:0] bexp [3];
      logic        hbexp [3];
      logic        lbexp [3];
      bexp  = '{16'h0080, 16'h8000, 16'hFF80};
      hbexp = '{1'b0, 1'b1, 1'b1};
      lbexp = '{1'b1, 1'b0, 1'b1};
      m_byte[0] = '0;
      m_byte[1] = '0;

      step(1, 1, 16'hAAAA, 3'd7, 2'd0, 1, 8'hFF);
      step(1, 0, 16'h0, 3'd0, 2'd0, 0, 8'h00);
      lit("reset busy", 32'(busy), 32'h0);
      lit("reset rf_data", 32'(rf_data), 32'h0);

      // Word load, zero wait.
      step(0, 1, 16'h1234, 3'd5, 2'd0, 0, 8'h00);
      lit("word c1 mem_req", 32'(mem_req), 32'h1);
      lit("word c1 mem_addr", 32'(mem_addr), 32'h1234);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'hCD);
      lit("word c2 mem_addr", 32'(mem_addr), 32'h1235);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'hAB);
      lit("word c3 rf_we", 32'(rf_we), 32'h1);
      lit("word c3 rf_dest", 32'(rf_dest), 32'h5);
      lit("word c3 rf_data", 32'(rf_data), 32'hABCD);
      lit("word c3 hb/lb", 32'({rf_hb, rf_lb}), 32'h3);
      lit("word c3 done", 32'(done), 32'h1);
      idle(0);

      // Byte modes with 0x80.
      for (int m = 1; m <= 3; m++) begin
         step(0, 1, 16'h2000, 3'(m), 2'(m), 0, 8'h00);
         step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'h80);
         lit("byte c2 done", 32'(done), 32'h1);
         lit("byte c2 rf_data", 32'(rf_data), 32'(bexp[m-1]));
         lit("byte c2 hb", 32'(rf_hb), 32'(hbexp[m-1]));
         lit("byte c2 lb", 32'(rf_lb), 32'(lbexp[m-1]));
         idle(0);
      end

      // Wait states and address wrap.
      step(0, 1, 16'hFFFF, 3'd7, 2'd0, 0, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         lit("wrap mem_addr", 32'(mem_addr), (c <= 4) ? 32'hFFFF : 32'h0000);
         step(0, 0, 16'h0, 3'd0, 2'd0, (c == 4 || c == 8), (c == 4) ? 8'h11 : 8'h22);
      end
      lit("wrap c9 done", 32'(done), 32'h1);
      lit("wrap c9 rf_data", 32'(rf_data), 32'h2211);
      idle(0);

      // Busy rejection and stray ack.
      idle(1);
      step(0, 1, 16'h4000, 3'd2, 2'd0, 1, 8'hEE);
      step(0, 1, 16'h5555, 3'd6, 2'd1, 0, 8'h00);
      step(0, 1, 16'h5555, 3'd6, 2'd1, 1, 8'h34);
      lit("busy c3 mem_addr", 32'(mem_addr), 32'h4001);
      step(0, 1, 16'h5555, 3'd6, 2'd1, 0, 8'h00);
      step(0, 1, 16'h5555, 3'd6, 2'd1, 1, 8'h12);
      lit("busy c5 rf_dest", 32'(rf_dest), 32'h2);
      lit("busy c5 rf_data", 32'(rf_data), 32'h1234);
      step(0, 1, 16'h5555, 3'd6, 2'd1, 1, 8'h00);
      lit("busy c6 busy", 32'(busy), 32'h0);
      lit("busy c6 mem_req", 32'(mem_req), 32'h0);
      idle(1);

      // Reset during RD1 with ack.
      step(0, 1, 16'h3000, 3'd1, 2'd0, 0, 8'h00);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'h55);
      step(1, 0, 16'h0, 3'd0, 2'd0, 1, 8'h66);
      lit("rst busy", 32'(busy), 32'h0);
      lit("rst mem_req", 32'(mem_req), 32'h0);
      lit("rst mem_addr", 32'(mem_addr), 32'h0);
      lit("rst rf_we", 32'(rf_we), 32'h0);
      idle(0);
      step(0, 1, 16'h3000, 3'd3, 2'd3, 0, 8'h00);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'h7F);
      lit("post-rst rf_data", 32'(rf_data), 32'h007F);

      // Back-to-back: start during WB ignored, start after WB accepted.
      idle(0);
      step(0, 1, 16'h0100, 3'd4, 2'd1, 0, 8'h00);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'h9A);
      lit("b2b first rf_data", 32'(rf_data), 32'h009A);
      step(0, 1, 16'h0300, 3'd1, 2'd0, 0, 8'h00);
      step(0, 1, 16'h0200, 3'd6, 2'd2, 0, 8'h00);
      lit("b2b second mem_addr", 32'(mem_addr), 32'h0200);
      step(0, 0, 16'h0, 3'd0, 2'd0, 1, 8'hBC);
      lit("b2b second rf_dest", 32'(rf_dest), 32'h6);
      lit("b2b second rf_data", 32'(rf_data), 32'hBC00);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), ra,
              3'($urandom), 2'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
